// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the single main-memory port: instruction fetch vs. data refill/write-back.
// Each granted request holds the port for MEM_LAT cycles, then pulses the owner's done for one cycle.
module mem_port_arbiter #(
  parameter int XLEN    = 32,
  parameter int MEM_LAT = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_req,
  input  logic [XLEN-1:0] i_addr,
  output logic            i_done,
  output logic            i_stall,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wd,
  output logic            d_done,
  output logic            d_stall,
  output logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wd,
  output logic            mem_we,
  input  logic [XLEN-1:0] mem_rd
);

  localparam int CW = $clog2(MEM_LAT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LAT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t          state, state_nxt;
  logic            owner_d;
  logic            last_d;
  logic [XLEN-1:0] lat_addr;
  logic [XLEN-1:0] lat_wd;
  logic            lat_we;
  logic [CW-1:0]   cnt;
  logic            grant_i, grant_d, cap;
  logic            in_acc, in_done;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Grants are only evaluated in IDLE, so a req still held during DONE cannot re-grant early.
  always_comb begin
    state_nxt = state;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    cap       = 1'b0;
    case (state)
      IDLE: begin
        grant_d = d_req && (!i_req || !last_d);
        grant_i = i_req && !grant_d;
        if (grant_d || grant_i) state_nxt = ACCESS;
      end
      ACCESS: begin
        if (cnt == CNT_LAST) begin
          cap       = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_d  <= 1'b0;
      last_d   <= 1'b0;
      lat_addr <= '0;
      lat_wd   <= '0;
      lat_we   <= 1'b0;
      cnt      <= '0;
      rdata    <= '0;
    end else begin
      if (grant_d) begin
        owner_d  <= 1'b1;
        lat_addr <= d_addr;
        lat_wd   <= d_wd;
        lat_we   <= d_we;
        cnt      <= '0;
      end else if (grant_i) begin
        owner_d  <= 1'b0;
        lat_addr <= i_addr;
        lat_wd   <= '0;
        lat_we   <= 1'b0;
        cnt      <= '0;
      end else if (state == ACCESS) begin
        cnt <= cnt + 1'b1;
      end
      // Captured for writes too; the owner simply ignores it.
      if (cap) rdata <= mem_rd;
      if (state == DONE) last_d <= owner_d;
    end
  end

  assign in_acc  = (state == ACCESS);
  assign in_done = (state == DONE);

  assign mem_addr = in_acc ? lat_addr : '0;
  assign mem_wd   = in_acc ? lat_wd   : '0;
  assign mem_we   = in_acc && lat_we;

  assign i_done  = in_done && !owner_d;
  assign d_done  = in_done &&  owner_d;
  assign i_stall = i_req && !i_done;
  assign d_stall = d_req && !d_done;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter and sequencer for the single main-memory port. It shares that port between the instruction-fetch path and the data cache's refill/write-back path. Each accepted request is latched and driven onto the memory port for a fixed `MEM_LAT` cycles. The read data is captured, and the owner receives a one-cycle `done`. It sits between the two caches and the RAM model, replacing their direct RAM connections.

## Interface
- `XLEN`, 32, address/data width
- `MEM_LAT`, 2, cycles the memory port is held per access (≥1)
- `clk`  in  1  clock
- `rst`  in  1  reset: synchronous, active-high
- `i_req`  in  1  instruction side request, held until `i_done`
- `i_addr`  in  XLEN  instruction address (read-only requester)
- `i_done`  out  1  one-cycle completion pulse to instruction side
- `i_stall`  out  1  `i_req && !i_done`
- `d_req`  in  1  data side request, held until `d_done`
- `d_we`  in  1  1 = write-back, 0 = refill read
- `d_addr`  in  XLEN  data address
- `d_wd`  in  XLEN  write-back data
- `d_done`  out  1  one-cycle completion pulse to data side
- `d_stall`  out  1  `d_req && !d_done`
- `rdata`  out  XLEN  captured read data, valid while the matching `done` is high
- `mem_addr`  out  XLEN  memory address
- `mem_wd`  out  XLEN  memory write data
- `mem_we`  out  1  memory write enable
- `mem_rd`  in  XLEN  memory read data, valid on the last ACCESS cycle

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE
  - If exactly one `req` is high, grant that side.
  - If both are high, grant the side not granted last (round-robin on the `last_d` bit).
  - On grant: latch owner, address, write data and we; clear the counter; go to ACCESS.
  - Instruction requests always latch we=0 and wd=0.
- ACCESS
  - Drive `mem_addr`/`mem_wd`/`mem_we` from the latched request for all `MEM_LAT` cycles.
  - Counter increments each cycle. Its width is `$clog2(MEM_LAT+1)`.
  - On the cycle with counter == `MEM_LAT-1`: register `mem_rd` into `rdata`, even for writes, and go to DONE.
- DONE
  - Assert the owner's `done` for exactly one cycle.
  - `rdata` holds until the next capture.
  - Set `last_d` = (owner == data).
  - Always go to IDLE. The owner's `req` is still high in this cycle and must not be re-granted.
- Memory outputs are 0 in IDLE and DONE.
- `req` or inputs changing during ACCESS/DONE are ignored; the latched copy is used.
- A requester that drops `req` mid-access still gets its `done` pulse and may ignore it. The access is not aborted.
- Never assert `i_done` and `d_done` together. A `done` never goes to a non-owner.

## Timing
- `req` sampled high in IDLE at cycle N:
  - ACCESS occupies cycles N+1 … N+`MEM_LAT`.
  - `done` is high in cycle N+`MEM_LAT`+1.
  - IDLE returns at N+`MEM_LAT`+2.
- Throughput: one access per `MEM_LAT`+2 cycles.
- Contending requests alternate. The loser waits exactly one full access plus one IDLE cycle.
- Reset values: state IDLE, `last_d`=0 (data side wins the first tie), counter 0, latches 0, `rdata` 0, `i_done`/`d_done` 0, `mem_addr`/`mem_wd`/`mem_we` 0. `stall` outputs follow `req`.
- Reset mid-ACCESS or in DONE:
  - Next cycle is IDLE with `mem_we`=0.
  - No `done` is issued; requesters re-issue.
  - Reset has priority over all transitions.
- `MEM_LAT`=1: a single ACCESS cycle, and capture happens in that cycle.

## Test plan
- Reset, then `d_req`=1 read at 0x0000_1000 with `mem_rd`=0xDEADBEEF → `mem_addr`=0x1000 for 2 cycles, `mem_we`=0, `d_done` at cycle +3 with `rdata`=0xDEADBEEF, `i_done` stays 0.
- `d_req` write, `d_addr`=0x0000_2004, `d_wd`=0x12345678 → `mem_we`=1 with that address/data for exactly 2 cycles, then `d_done` pulse; `mem_we`=0 in DONE.
- `i_req` and `d_req` high together from reset, both held → grant order D, I, D, I; each `done` one cycle; no overlap of memory drives.
- `d_req` held continuously after `d_done` → DONE→IDLE→new ACCESS; no double-grant inside the DONE cycle; 4-cycle period at `MEM_LAT`=2.
- `rst` asserted on the 1st ACCESS cycle of a write → next cycle IDLE, `mem_we`=0, no `done`; after release the held request re-runs to completion.
- `MEM_LAT`=1 build, `i_req` at 0x40 with `mem_rd`=0x00500093 → one ACCESS cycle, `i_done` at cycle +2, `rdata`=0x00500093.
